// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the multi-channel tick scheduler.
package timer_sched_pkg;

    // Channel mode encoding as seen on cfg_mode_i
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Clock cycles per tick when the instantiator does not override it
    localparam int unsigned DefaultPrescale = 12;

    // Event port sequencing
    typedef enum logic [0:0] {
        StIdle,
        StOffer
    } evt_state_e;

endpackage

// File: rtl/timer_rr_arb.sv
// Combinational round-robin pick: first set bit of pending_i at or after rr_i, wrapping at NCH.
module timer_rr_arb
    import timer_sched_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned ChW = $clog2(NCH)
) (
    input  logic [NCH-1:0] pending_i,
    input  logic [ChW-1:0] rr_i,
    output logic [ChW-1:0] grant_o,
    output logic           any_o
);

    // One extra bit so rr + offset cannot overflow before the explicit wrap
    logic [ChW:0] idx;

    // Scan NCH positions starting at rr_i and keep the first pending one
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = {1'b0, rr_i} + (ChW+1)'(i);
            if (idx >= (ChW+1)'(NCH)) begin
                idx = idx - (ChW+1)'(NCH);
            end
            if (!any_o && pending_i[idx[ChW-1:0]]) begin
                any_o   = 1'b1;
                grant_o = idx[ChW-1:0];
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel tick scheduler: shared prescaler, NCH down-counting channels and a
// round-robin valid/ready event port.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter  int unsigned NCH      = 4,
    parameter  int unsigned CW       = 8,
    parameter  int unsigned PRESCALE = DefaultPrescale,
    localparam int unsigned ChW      = $clog2(NCH)
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           cfg_we_i,
    input  logic [ChW-1:0] cfg_ch_i,
    input  logic [CW-1:0]  cfg_period_i,
    input  logic           cfg_mode_i,
    input  logic           cfg_en_i,
    output logic           evt_valid_o,
    output logic [ChW-1:0] evt_ch_o,
    input  logic           evt_ready_i,
    output logic [NCH-1:0] active_o,
    output logic [NCH-1:0] overrun_o,
    output logic           tick_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]            presc_q;
    logic                     tick;

    logic [NCH-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0][CW-1:0]   per_q, per_d;
    logic [NCH-1:0]           mode_q, mode_d;
    logic [NCH-1:0]           active_q, active_d;
    logic [NCH-1:0]           pending_q, pending_d;
    logic [NCH-1:0]           overrun_q, overrun_d;

    logic [NCH-1:0]           cfg_hit;
    logic [NCH-1:0]           accept;
    logic [NCH-1:0]           expire;

    evt_state_e               state_q;
    logic                     evt_valid_q;
    logic [ChW-1:0]           evt_ch_q;
    logic [ChW-1:0]           rr_q;

    logic [ChW-1:0]           arb_grant;
    logic                     arb_any;

    assign tick = (presc_q == PW'(PRESCALE - 1));

    // Prescaler: free-running 0..PRESCALE-1
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Per-channel strobes; an out-of-range cfg_ch_i matches no channel
    always_comb begin
        cfg_hit = '0;
        accept  = '0;
        expire  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            cfg_hit[c] = cfg_we_i && (cfg_ch_i == ChW'(c));
            accept[c]  = (state_q == StOffer) && evt_ready_i && (evt_ch_q == ChW'(c));
            expire[c]  = tick && active_q[c] && !cfg_hit[c] && (cnt_q[c] == CW'(1));
        end
    end

    // Channel next state: config write beats counting; expiry beats acceptance
    always_comb begin
        cnt_d     = cnt_q;
        per_d     = per_q;
        mode_d    = mode_q;
        active_d  = active_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (cfg_hit[c]) begin
                per_d[c]     = cfg_period_i;
                cnt_d[c]     = cfg_period_i;
                mode_d[c]    = cfg_mode_i;
                active_d[c]  = cfg_en_i && (cfg_period_i != '0);
                pending_d[c] = 1'b0;
                overrun_d[c] = 1'b0;
            end else begin
                if (tick && active_q[c]) begin
                    if (cnt_q[c] == CW'(1)) begin
                        if (mode_q[c] == MODE_ONESHOT) begin
                            active_d[c] = 1'b0;
                        end else begin
                            cnt_d[c] = per_q[c];
                        end
                    end else if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - CW'(1);
                    end
                end
                if (expire[c]) begin
                    // A second expiry before the first was consumed is only flagged
                    if (pending_q[c] && !accept[c]) begin
                        overrun_d[c] = 1'b1;
                    end
                    pending_d[c] = 1'b1;
                end else if (accept[c]) begin
                    pending_d[c] = 1'b0;
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cnt_q     <= '0;
            per_q     <= '0;
            mode_q    <= '0;
            active_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            mode_q    <= mode_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    timer_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .pending_i (pending_q),
        .rr_i      (rr_q),
        .grant_o   (arb_grant),
        .any_o     (arb_any)
    );

    // Event FSM: pick in IDLE, hold the offer stable until accepted
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        evt_ch_q    <= arb_grant;
                        evt_valid_q <= 1'b1;
                        state_q     <= StOffer;
                    end
                end
                StOffer: begin
                    if (evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        rr_q        <= (evt_ch_q == ChW'(NCH - 1)) ? '0 : evt_ch_q + ChW'(1);
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign active_o    = active_q;
    assign overrun_o   = overrun_q;
    assign tick_o      = tick;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched with a per-cycle behavioural reference model.
module tb_timer_sched;

    localparam int NCH      = 4;
    localparam int CW       = 8;
    localparam int PRESCALE = 12;
    localparam int CHW      = 2;
    localparam int OW       = 1 + CHW + NCH + NCH + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic           cfg_mode = 1'b0;
    logic           cfg_en = 1'b0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [CHW-1:0] evt_ch;
    logic [NCH-1:0] active;
    logic [NCH-1:0] overrun;
    logic           tick;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    int m_presc;
    int m_cnt  [NCH];
    int m_per  [NCH];
    bit m_mode [NCH];
    bit m_act  [NCH];
    bit m_pend [NCH];
    bit m_ovr  [NCH];
    bit m_valid;
    int m_ch;
    int m_rr;

    timer_sched #(
        .NCH      (NCH),
        .CW       (CW),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_period_i (cfg_period),
        .cfg_mode_i   (cfg_mode),
        .cfg_en_i     (cfg_en),
        .evt_valid_o  (evt_valid),
        .evt_ch_o     (evt_ch),
        .evt_ready_i  (evt_ready),
        .active_o     (active),
        .overrun_o    (overrun),
        .tick_o       (tick)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_presc = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_per[c] = 0; m_mode[c] = 0;
            m_act[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
        m_valid = 0; m_ch = 0; m_rr = 0;
    endfunction

    function automatic logic [OW-1:0] m_obs();
        logic [NCH-1:0] a, o;
        for (int c = 0; c < NCH; c++) begin
            a[c] = m_act[c];
            o[c] = m_ovr[c];
        end
        return {m_valid, m_valid ? CHW'(m_ch) : CHW'(0), a, o, m_presc == PRESCALE - 1};
    endfunction

    function automatic logic [OW-1:0] dut_obs();
        return {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun, tick};
    endfunction

    // Advance model by the spec rules using current inputs, then one DUT clock.
    task automatic cycle();
        bit tk, acc, ex, hit, found;
        bit old_pend [NCH];
        int acc_ch, idx;
        if (!rst_n) begin
            model_clear();
        end else begin
            tk = (m_presc == PRESCALE - 1);
            acc = m_valid && evt_ready;
            acc_ch = m_ch;
            old_pend = m_pend;
            for (int c = 0; c < NCH; c++) begin
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_per[c] = int'(cfg_period);
                    m_cnt[c] = int'(cfg_period);
                    m_mode[c] = cfg_mode;
                    m_act[c] = cfg_en && (cfg_period != 0);
                    m_pend[c] = 0;
                    m_ovr[c] = 0;
                end else begin
                    ex = tk && m_act[c] && m_cnt[c] == 1;
                    hit = acc && acc_ch == c;
                    if (tk && m_act[c]) begin
                        if (m_cnt[c] == 1) begin
                            if (m_mode[c]) m_act[c] = 0;
                            else m_cnt[c] = m_per[c];
                        end else begin
                            m_cnt[c] = m_cnt[c] - 1;
                        end
                    end
                    if (ex) begin
                        if (m_pend[c] && !hit) m_ovr[c] = 1;
                        m_pend[c] = 1;
                    end else if (hit) begin
                        m_pend[c] = 0;
                    end
                end
            end
            if (m_valid) begin
                if (evt_ready) begin
                    m_valid = 0;
                    m_rr = (m_ch + 1) % NCH;
                end
            end else begin
                found = 0;
                for (int i = 0; i < NCH; i++) begin
                    idx = (m_rr + i) % NCH;
                    if (!found && old_pend[idx]) begin
                        found = 1;
                        m_ch = idx;
                        m_valid = 1;
                    end
                end
            end
            m_presc = tk ? 0 : m_presc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; cfg_we = 0; evt_ready = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    task automatic write_cfg(input int ch, input int per, input bit mode, input bit en);
        cfg_we = 1; cfg_ch = CHW'(ch); cfg_period = CW'(per); cfg_mode = mode; cfg_en = en;
        cycle();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        rst_n = 0;
        cfg_ch = 2; cfg_period = 2; cfg_en = 1; cfg_mode = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_we = i[0];
            cycle();
            n_cmp++;
            if ({evt_valid, active, overrun, tick} !== '0) begin
                n_bad++;
                $display("FAIL reset_state: got valid=%b active=%b overrun=%b tick=%b, want all 0",
                         evt_valid, active, overrun, tick);
            end
        end
        cfg_we = 0;
        rst_n = 1;
        for (int i = 0; i < 36; i++) begin
            cycle();
            if (tick) ticks++;
            n_cmp++;
            if (tick !== (i == 10 || i == 22 || i == 34)) begin
                n_bad++;
                $display("FAIL reset_tick_phase: cycle %0d got tick=%b", i, tick);
            end
        end
        n_cmp++;
        if (ticks !== 3) begin
            n_bad++;
            $display("FAIL reset_tick_count: got %0d ticks want 3", ticks);
        end
    endtask

    task automatic test_periodic();
        int acc_t[$];
        int wcyc;
        do_reset();
        evt_ready = 1;
        cycle();
        wcyc = cyc;
        write_cfg(0, 3, 0, 1);
        for (int i = 0; i < 150; i++) begin
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs()) begin
                n_bad++;
                $display("FAIL periodic_model: got %h want %h", dut_obs(), m_obs());
            end
            if (evt_valid && evt_ready) begin
                acc_t.push_back(cyc);
                n_cmp++;
                if (evt_ch !== 0 || overrun !== '0) begin
                    n_bad++;
                    $display("FAIL periodic_event: got ch=%0d overrun=%b want ch=0 overrun=0",
                             evt_ch, overrun);
                end
            end
        end
        n_cmp++;
        if (acc_t.size() < 3 || acc_t[0] - wcyc < 24 || acc_t[0] - wcyc > 40) begin
            n_bad++;
            $display("FAIL periodic_first: got %0d events, first at +%0d want >=3 at +24..40",
                     acc_t.size(), acc_t.size() > 0 ? acc_t[0] - wcyc : -1);
        end
        for (int k = 1; k < acc_t.size(); k++) begin
            n_cmp++;
            if (acc_t[k] - acc_t[k-1] !== 36) begin
                n_bad++;
                $display("FAIL periodic_interval: got %0d want 36", acc_t[k] - acc_t[k-1]);
            end
        end
    endtask

    task automatic test_oneshot();
        int nev = 0, falls = 0;
        bit prev_act, prev_tick;
        do_reset();
        evt_ready = 1;
        write_cfg(1, 2, 1, 1);
        prev_act = active[1];
        prev_tick = tick;
        for (int i = 0; i < 230; i++) begin
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs()) begin
                n_bad++;
                $display("FAIL oneshot_model: got %h want %h", dut_obs(), m_obs());
            end
            if (prev_act && !active[1]) begin
                falls++;
                n_cmp++;
                if (!prev_tick) begin
                    n_bad++;
                    $display("FAIL oneshot_drop: active[1] fell without tick, got tick=0 want 1");
                end
            end
            if (evt_valid && evt_ready) begin
                nev++;
                n_cmp++;
                if (evt_ch !== 1) begin
                    n_bad++;
                    $display("FAIL oneshot_ch: got %0d want 1", evt_ch);
                end
            end
            prev_act = active[1];
            prev_tick = tick;
        end
        n_cmp++;
        if (nev !== 1 || falls !== 1) begin
            n_bad++;
            $display("FAIL oneshot_count: got events=%0d falls=%0d want 1 and 1", nev, falls);
        end
    endtask

    task automatic test_rotation();
        int seq[$];
        int tms[$];
        do_reset();
        evt_ready = 1;
        for (int c = 0; c < NCH; c++) write_cfg(c, 1, 0, 1);
        for (int i = 0; i < 100; i++) begin
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs()) begin
                n_bad++;
                $display("FAIL rotation_model: got %h want %h", dut_obs(), m_obs());
            end
            if (evt_valid && evt_ready) begin
                seq.push_back(int'(evt_ch));
                tms.push_back(cyc);
            end
        end
        n_cmp++;
        if (seq.size() < 24 || overrun !== '0) begin
            n_bad++;
            $display("FAIL rotation_count: got %0d events overrun=%b want >=24 and 0",
                     seq.size(), overrun);
        end
        for (int k = 0; k < seq.size(); k++) begin
            n_cmp++;
            if (seq[k] !== k % NCH || (k % NCH != 0 && tms[k] - tms[k-1] !== 2)) begin
                n_bad++;
                $display("FAIL rotation_order: event %0d got ch=%0d gap=%0d want ch=%0d gap=2",
                         k, seq[k], k > 0 ? tms[k] - tms[k-1] : 0, k % NCH);
            end
        end
    endtask

    task automatic test_overrun();
        int nacc = 0;
        do_reset();
        evt_ready = 0;
        write_cfg(2, 1, 0, 1);
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs() || (evt_valid && evt_ch !== 2)) begin
                n_bad++;
                $display("FAIL overrun_hold: got %h want %h", dut_obs(), m_obs());
            end
        end
        n_cmp++;
        if (evt_valid !== 1 || evt_ch !== 2 || overrun[2] !== 1) begin
            n_bad++;
            $display("FAIL overrun_flag: got valid=%b ch=%0d ovr=%b want 1 2 1",
                     evt_valid, evt_ch, overrun[2]);
        end
        evt_ready = 1;
        for (int i = 0; i < 6 && nacc == 0; i++) begin
            if (evt_valid && evt_ready) nacc++;
            cycle();
        end
        evt_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs()) begin
                n_bad++;
                $display("FAIL overrun_after: got %h want %h", dut_obs(), m_obs());
            end
        end
        n_cmp++;
        if (nacc !== 1 || overrun[2] !== 1) begin
            n_bad++;
            $display("FAIL overrun_accept: got acc=%0d ovr=%b want 1 and 1", nacc, overrun[2]);
        end
        write_cfg(2, 1, 0, 0);
        n_cmp++;
        if (overrun[2] !== 0 || active[2] !== 0) begin
            n_bad++;
            $display("FAIL overrun_clear: got ovr=%b act=%b want 0 0", overrun[2], active[2]);
        end
    endtask

    task automatic test_zero_and_reset();
        int w = 0;
        do_reset();
        evt_ready = 1;
        write_cfg(3, 0, 0, 1);
        for (int i = 0; i < 50; i++) begin
            cycle();
            n_cmp++;
            if (active[3] !== 0 || evt_valid !== 0) begin
                n_bad++;
                $display("FAIL zero_period: got act3=%b valid=%b want 0 0", active[3], evt_valid);
            end
        end
        evt_ready = 0;
        write_cfg(1, 1, 0, 1);
        while (!evt_valid && w < 40) begin
            cycle();
            w++;
        end
        n_cmp++;
        if (!evt_valid) begin
            n_bad++;
            $display("FAIL reset_offer_wait: got no offer in 40 cycles, want valid=1");
        end
        rst_n = 0;
        cycle();
        n_cmp++;
        if (evt_valid !== 0 || active !== '0) begin
            n_bad++;
            $display("FAIL reset_offer: got valid=%b active=%b want 0 0", evt_valid, active);
        end
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_cmp++;
            if (evt_valid !== 0) begin
                n_bad++;
                $display("FAIL reset_lost: got valid=1 at cycle %0d want 0", i);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            evt_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_ch = CHW'($urandom_range(0, NCH - 1));
            cfg_period = CW'($urandom_range(0, 4));
            cfg_mode = $urandom_range(0, 1);
            cfg_en = ($urandom_range(0, 4) != 0);
            cycle();
            n_cmp++;
            if (dut_obs() !== m_obs()) begin
                n_bad++;
                $display("FAIL random_model: cycle %0d got %h want %h", i, dut_obs(), m_obs());
            end
        end
        cfg_we = 0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_periodic();
        test_oneshot();
        test_rotation();
        test_overrun();
        test_zero_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
